// File: rtl/mode_sequencer_if.sv
// Front-panel bus of the mode sequencer: tick strobe and raw keys in,
// mode-selector and stopwatch controls out.
interface mode_sequencer_if;
    logic       tick_en;
    logic       key_mode;
    logic       key_set;
    logic       key_hour;
    logic       key_min;
    logic [1:0] tube_for;
    logic       is_manual_set;
    logic       sw_hour;
    logic       sw_min;
    logic       sw_run;
    logic       sw_clear;

    modport master (
        output tick_en, key_mode, key_set, key_hour, key_min,
        input  tube_for, is_manual_set, sw_hour, sw_min, sw_run, sw_clear
    );

    modport slave (
        input  tick_en, key_mode, key_set, key_hour, key_min,
        output tube_for, is_manual_set, sw_hour, sw_min, sw_run, sw_clear
    );
endinterface

// File: rtl/mode_sequencer.sv
// Digital-clock front-panel controller: key synchronise/debounce, mode FSM,
// hour/min auto-repeat, idle timeout and stopwatch run/clear control.
module mode_sequencer #(
    parameter int DEB_TICKS = 3,
    parameter int REP_DELAY = 50,
    parameter int REP_RATE  = 10,
    parameter int TIMEOUT   = 1000,
    parameter int CW        = 10
) (
    input  logic            clk,
    input  logic            rst,
    mode_sequencer_if.slave bus
);
    localparam int DW     = $clog2(DEB_TICKS + 1);
    localparam int K_MODE = 0;
    localparam int K_SET  = 1;
    localparam int K_HOUR = 2;
    localparam int K_MIN  = 3;

    typedef enum logic [1:0] {
        ST_CLOCK     = 2'd0,
        ST_CLOCK_SET = 2'd1,
        ST_STOPWATCH = 2'd2,
        ST_ALARM     = 2'd3
    } state_t;

    typedef struct packed {
        logic          arm;
        logic          fire;
        logic [CW-1:0] cnt;
    } rep_t;

    logic [3:0]         w_key_raw, r_sync1, r_sync2, r_deb, r_deb_d, w_press;
    logic [3:0][DW-1:0] r_deb_cnt;
    state_t             r_state, w_next;
    logic               w_in_sa, w_keep, w_expire;
    logic [CW-1:0]      r_rep_h, r_rep_m, r_idle, w_idle_nx;
    logic               r_arm_h, r_arm_m;
    rep_t               w_rep_h, w_rep_m;
    logic [1:0]         r_tube_for, w_tube_for_nx;
    logic               r_manual, w_manual_nx;
    logic               r_sw_hour, w_sw_hour_nx, r_sw_min, w_sw_min_nx;
    logic               r_sw_run, w_sw_run_nx, r_sw_clear, w_sw_clear_nx;

    // Repeat counter step: arms on press, first fire at REP_DELAY ticks, then
    // reloads so the next fire lands REP_RATE ticks later.
    function automatic rep_t rep_step(input logic in_sa, input logic keep,
                                      input logic deb, input logic press,
                                      input logic arm, input logic tick,
                                      input logic [CW-1:0] cnt);
        rep_t r;
        r.arm  = arm;
        r.fire = 1'b0;
        r.cnt  = cnt;
        if (!in_sa || !keep || !deb) begin
            r.arm = 1'b0;
            r.cnt = '0;
        end else if (press) begin
            r.arm = 1'b1;
            r.cnt = '0;
        end else if (arm && tick) begin
            if (cnt == CW'(REP_DELAY - 1)) begin
                r.fire = 1'b1;
                r.cnt  = CW'(REP_DELAY - REP_RATE);
            end else begin
                r.cnt = cnt + CW'(1);
            end
        end else begin
            r.cnt = cnt;
        end
        return r;
    endfunction

    assign w_key_raw = {bus.key_min, bus.key_hour, bus.key_set, bus.key_mode};
    assign w_press   = r_deb & ~r_deb_d;
    assign w_in_sa   = (r_state == ST_CLOCK_SET) || (r_state == ST_ALARM);
    assign w_expire  = w_in_sa && bus.tick_en && !(|w_press) && !r_arm_h && !r_arm_m
                       && (r_idle == CW'(TIMEOUT - 1));

    // Key synchronisers and tick-sampled debounce
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1   <= 4'b0;
            r_sync2   <= 4'b0;
            r_deb     <= 4'b0;
            r_deb_d   <= 4'b0;
            r_deb_cnt <= '0;
        end else begin
            r_sync1 <= w_key_raw;
            r_sync2 <= r_sync1;
            r_deb_d <= r_deb;
            if (bus.tick_en) begin
                for (int k = 0; k < 4; k++) begin
                    if (r_sync2[k] == r_deb[k]) begin
                        r_deb_cnt[k] <= '0;
                    end else if (r_deb_cnt[k] == DW'(DEB_TICKS - 1)) begin
                        r_deb[k]     <= ~r_deb[k];
                        r_deb_cnt[k] <= '0;
                    end else begin
                        r_deb_cnt[k] <= r_deb_cnt[k] + DW'(1);
                    end
                end
            end
        end
    end

    // Next state, repeat/idle counters and next output values
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_CLOCK: begin
                if (w_press[K_MODE])     w_next = ST_STOPWATCH;
                else if (w_press[K_SET]) w_next = ST_CLOCK_SET;
                else                     w_next = ST_CLOCK;
            end
            ST_CLOCK_SET: begin
                if (w_press[K_MODE] || w_press[K_SET] || w_expire) w_next = ST_CLOCK;
                else                                               w_next = ST_CLOCK_SET;
            end
            ST_STOPWATCH: begin
                if (w_press[K_MODE]) w_next = ST_ALARM;
                else                 w_next = ST_STOPWATCH;
            end
            ST_ALARM: begin
                if (w_press[K_MODE] || w_expire) w_next = ST_CLOCK;
                else                             w_next = ST_ALARM;
            end
            default: w_next = ST_CLOCK;
        endcase

        w_keep  = (w_next == r_state);
        w_rep_h = rep_step(w_in_sa, w_keep, r_deb[K_HOUR], w_press[K_HOUR],
                           r_arm_h, bus.tick_en, r_rep_h);
        w_rep_m = rep_step(w_in_sa, w_keep, r_deb[K_MIN], w_press[K_MIN],
                           r_arm_m, bus.tick_en, r_rep_m);

        if (!w_in_sa || !w_keep || (|w_press) || r_arm_h || r_arm_m) begin
            w_idle_nx = '0;
        end else if (bus.tick_en && (r_idle != CW'(TIMEOUT))) begin
            w_idle_nx = r_idle + CW'(1);
        end else begin
            w_idle_nx = r_idle;
        end

        w_sw_hour_nx  = w_in_sa && (w_press[K_HOUR] || w_rep_h.fire);
        w_sw_min_nx   = w_in_sa && (w_press[K_MIN] || w_rep_m.fire);
        w_sw_clear_nx = (r_state == ST_STOPWATCH) && w_press[K_HOUR];

        // Clear beats a same-clk set toggle; mode press discards set
        if (w_sw_clear_nx) begin
            w_sw_run_nx = 1'b0;
        end else if ((r_state == ST_STOPWATCH) && w_press[K_SET] && !w_press[K_MODE]) begin
            w_sw_run_nx = ~r_sw_run;
        end else begin
            w_sw_run_nx = r_sw_run;
        end

        case (w_next)
            ST_STOPWATCH: w_tube_for_nx = 2'd1;
            ST_ALARM:     w_tube_for_nx = 2'd2;
            default:      w_tube_for_nx = 2'd0;
        endcase
        w_manual_nx = (w_next == ST_CLOCK_SET);
    end

    // State, counters and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_CLOCK;
            r_rep_h    <= '0;
            r_rep_m    <= '0;
            r_arm_h    <= 1'b0;
            r_arm_m    <= 1'b0;
            r_idle     <= '0;
            r_tube_for <= 2'd0;
            r_manual   <= 1'b0;
            r_sw_hour  <= 1'b0;
            r_sw_min   <= 1'b0;
            r_sw_run   <= 1'b0;
            r_sw_clear <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_rep_h    <= w_rep_h.cnt;
            r_rep_m    <= w_rep_m.cnt;
            r_arm_h    <= w_rep_h.arm;
            r_arm_m    <= w_rep_m.arm;
            r_idle     <= w_idle_nx;
            r_tube_for <= w_tube_for_nx;
            r_manual   <= w_manual_nx;
            r_sw_hour  <= w_sw_hour_nx;
            r_sw_min   <= w_sw_min_nx;
            r_sw_run   <= w_sw_run_nx;
            r_sw_clear <= w_sw_clear_nx;
        end
    end

    assign bus.tube_for      = r_tube_for;
    assign bus.is_manual_set = r_manual;
    assign bus.sw_hour       = r_sw_hour;
    assign bus.sw_min        = r_sw_min;
    assign bus.sw_run        = r_sw_run;
    assign bus.sw_clear      = r_sw_clear;
endmodule

// File: doc/mode_sequencer.md
Name: mode_sequencer

Overview:
- Front-panel controller that sequences the display/set datapath of the digital clock.
- Debounces the four panel keys (mode, set, hour, min) and runs the mode FSM.
- Drives the mode selector's tube_for, is_manual_set, sw_hour and sw_min inputs, plus the stopwatch run/clear controls.
- All timing is counted in tick_en strobes (nominally 100 Hz) on the single system clock.

Parameters:
- DEB_TICKS, 3, consecutive stable tick samples needed to accept a key level change
- REP_DELAY, 50, ticks a hour/min key must be held before auto-repeat starts
- REP_RATE, 10, ticks between auto-repeat pulses
- TIMEOUT, 1000, idle ticks in CLOCK_SET or ALARM before returning to CLOCK
- CW, 10, width of the timing counters; must hold max(REP_DELAY, TIMEOUT)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- tick_en  in  1  one-clk strobe per timing tick
- key_mode  in  1  raw mode key, active-high, asynchronous to clk
- key_set  in  1  raw set key, active-high
- key_hour  in  1  raw hour key, active-high
- key_min  in  1  raw minute key, active-high
- tube_for  out  2  display target: 0=CLOCK, 1=STOPWATCH, 2=ALARM (3 never driven)
- is_manual_set  out  1  high in CLOCK_SET only
- sw_hour  out  1  one-clk hour-increment pulse
- sw_min  out  1  one-clk minute-increment pulse
- sw_run  out  1  stopwatch run level
- sw_clear  out  1  one-clk stopwatch clear pulse

Behaviour:
- One clock; reset is asynchronous and active-high.
- Reset values: state=CLOCK, tube_for=0, is_manual_set=0, sw_hour=0, sw_min=0, sw_run=0, sw_clear=0.
- Reset clears all counters, synchronisers and debounced levels to 0.
- Reset asserted mid-operation aborts everything immediately; no pulse may be emitted in the reset cycle or the first clk after release.
- Input path: each key passes a 2-FF synchroniser.
- Debounce: per key, sample on tick_en. The debounced level flips only after DEB_TICKS consecutive samples differ from it.
- Press event: a 0->1 transition of the debounced level, one clk wide.
- FSM states: CLOCK(tube_for=0), CLOCK_SET(0, is_manual_set=1), STOPWATCH(1), ALARM(2).
- Transitions on mode press: CLOCK->STOPWATCH->ALARM->CLOCK; CLOCK_SET->CLOCK (abandons the set).
- Set press in CLOCK enters CLOCK_SET; set press in CLOCK_SET returns to CLOCK.
- Set press in STOPWATCH toggles sw_run. Set press in ALARM is ignored.
- If mode and set press in the same clk, mode wins and set is discarded.
- State change takes effect on the clk after the press event; outputs are registered.
- Hour/min pulses are emitted only in CLOCK_SET and ALARM:
  - one pulse on the press event;
  - if the key stays debounced-high, a pulse on the REP_DELAY-th tick after the press;
  - then one pulse every REP_RATE ticks until release.
  - Hour and min repeat independently and may pulse in the same clk.
- Pulses are suppressed in other states, and the repeat counters are held at 0 there.
- A state change clears both repeat counters, so a key held across a mode change produces no pulse until it is re-pressed.
- Hour press in STOPWATCH: sw_clear pulses one clk, and sw_run is forced to 0 on the same edge.
- Min press in STOPWATCH is ignored.
- Leaving STOPWATCH leaves sw_run unchanged (the stopwatch keeps running in the background).
- Idle timeout: in CLOCK_SET and ALARM, a counter increments on tick_en and clears on any press event or active auto-repeat. At TIMEOUT the FSM returns to CLOCK.
- A press in the same clk the timeout expires takes precedence: the state is kept and the counter clears.
- Counter arithmetic saturates at its terminal value; it never wraps.

Test Plan:
- Reset then idle: assert rst mid-run -> all outputs 0 asynchronously; tube_for=0 after release, with no pulses.
- Mode cycling: three clean mode presses (held 5 ticks, DEB_TICKS=3) -> tube_for 0->1->2->0, each change 1 clk after the debounced edge. A 2-tick glitch on key_mode -> no change.
- Auto-repeat: in CLOCK_SET, hold key_min 75 ticks -> sw_min pulses at the press, at tick 50, and at tick 60 and tick 70 (4 total); sw_hour stays 0.
- Stopwatch: in STOPWATCH, set press -> sw_run=1; hour press -> sw_clear one clk and sw_run=0. Then mode press to ALARM with sw_run=1 -> sw_run stays 1.
- Timeout: enter ALARM, no keys for 1000 ticks -> tube_for returns to 0. A press on tick 1000 -> stays in ALARM.
- Simultaneous events: mode+set press in the same clk from CLOCK -> STOPWATCH, is_manual_set=0. Hour held across a CLOCK_SET->CLOCK transition -> no sw_hour pulses afterwards.
